// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared operand width, op encodings and FSM state encodings for the mul/div datapath
package mul_div_unit_pkg;
  localparam int DATA_WIDTH = 32;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_CALC = 2'b01, S_DONE = 2'b10} state_e;
endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU; in_valid/in_ready+op/src_a/src_b in, out_valid/out_ready+hi/lo/div0 out, clk, rst active-low sync
module mul_div_unit #(
  parameter int DATA_WIDTH = mul_div_unit_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div0
);
  import mul_div_unit_pkg::*;
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  state_e r_state;
  logic [CW-1:0] r_cnt;
  logic r_go, r_div, r_neg_q, r_neg_r, r_bz, r_div0;
  logic [W-1:0] r_acc, r_q, r_b, r_hi, r_lo;
  logic w_sgn, w_a_neg, w_b_neg, w_bz;
  logic [W-1:0] w_a_mag, w_b_mag, w_acc_n, w_q_n, w_hi_f;
  logic [W:0] w_x, w_y;
  logic [W+1:0] w_sum;
  logic [2*W-1:0] w_prod;
  assign w_sgn = ~op[0];
  assign w_a_neg = w_sgn & src_a[W-1];
  assign w_b_neg = w_sgn & src_b[W-1];
  assign w_a_mag = w_a_neg ? -src_a : src_a;
  assign w_b_mag = w_b_neg ? -src_b : src_b;
  assign w_bz = op[1] & (src_b == '0);
  // shared adder: multiply adds the multiplicand, divide subtracts the divisor (carry out = no borrow)
  assign w_x = r_div ? {r_acc, r_q[W-1]} : {1'b0, r_acc};
  assign w_y = (r_div | r_q[0]) ? {1'b0, r_b} : '0;
  assign w_sum = {1'b0, w_x} + {1'b0, w_y ^ {(W+1){r_div}}} + {{(W+1){1'b0}}, r_div};
  assign w_acc_n = r_div ? (w_sum[W+1] ? w_sum[W-1:0] : w_x[W-1:0]) : w_sum[W:1];
  assign w_q_n = r_div ? {r_q[W-2:0], w_sum[W+1]} : {w_sum[0], r_q[W-1:1]};
  // low half of the negated double word is also the negated quotient
  assign w_prod = r_neg_q ? -{w_acc_n, w_q_n} : {w_acc_n, w_q_n};
  // divide-by-zero leaves |a| in the remainder, so the dividend-sign fix-up restores src_a
  assign w_hi_f = r_div ? (r_neg_r ? -w_acc_n : w_acc_n) : w_prod[2*W-1:W];
  assign in_ready = r_state == S_IDLE;
  assign out_valid = r_state == S_DONE;
  assign hi = r_hi;
  assign lo = r_lo;
  assign div0 = r_div0;
  always_ff @(posedge clk)
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_go <= 1'b0;
      r_div <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bz <= 1'b0;
      r_acc <= '0;
      r_q <= '0;
      r_b <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_div0 <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_div <= op[1];
          r_neg_q <= (w_a_neg ^ w_b_neg) & ~w_bz;
          r_neg_r <= op[1] & w_a_neg;
          r_bz <= w_bz;
          r_acc <= '0;
          r_q <= w_a_mag;
          r_b <= w_b_mag;
          r_cnt <= '0;
          r_go <= 1'b0;
          r_state <= S_CALC;
        end
        // first CALC cycle is a settle slot so the result lands DATA_WIDTH+1 cycles after accept
        S_CALC: if (!r_go) r_go <= 1'b1;
        else begin
          r_acc <= w_acc_n;
          r_q <= w_q_n;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W-1)) begin
            r_hi <= w_hi_f;
            r_lo <= w_prod[W-1:0];
            r_div0 <= r_bz;
            r_state <= S_DONE;
          end
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;
  localparam int W = 32;
  localparam int LAT = W + 1;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, div0;
  logic [1:0] op = 2'b00;
  logic [W-1:0] src_a = '0, src_b = '0, hi, lo;
  int n_chk = 0, n_bad = 0;
  mul_div_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .hi(hi), .lo(lo), .div0(div0)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op = ~o;
    src_a = $urandom;
    src_b = $urandom;
  endtask
  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!out_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(LAT));
  endtask
  task automatic take(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    chk({tag, "_div0"}, 64'(div0), 64'(ed));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ret"}, {62'd0, out_valid, in_ready}, 64'b01);
    chk({tag, "_keep"}, {hi, lo}, {eh, el});
  endtask
  task automatic run(input string tag, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
    start_op(o, a, b);
    chk({tag, "_busy"}, {62'd0, out_valid, in_ready}, 64'b00);
    wait_done(tag);
    take(tag, eh, el, ed);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int seen;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_hs", {62'd0, out_valid, in_ready}, 64'b01);
    chk("rst_res", {hi, lo}, 64'd0);
    chk("rst_div0", 64'(div0), 64'd0);
    run("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run("mult_nn", OP_MULT, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 1'b0);
    run("multu_big", OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0);
    run("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run("div_negb", OP_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run("divu_z", OP_DIVU, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1);
    run("divu_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run("div_z", OP_DIV, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
    start_op(OP_MULT, 32'hFFFFFFFB, 32'hFFFFFFFA);
    wait_done("stall");
    in_valid = 1'b1;
    op = OP_DIVU;
    src_a = 32'd3;
    src_b = 32'd4;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hs", {62'd0, out_valid, in_ready}, 64'b10);
      chk("stall_res", {hi, lo}, {32'h0, 32'h1E});
    end
    op = OP_MULTU;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", {62'd0, out_valid, in_ready}, 64'b01);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    src_a = $urandom;
    chk("b2b_acc", {62'd0, out_valid, in_ready}, 64'b00);
    wait_done("b2b");
    take("b2b", 32'd0, 32'd12, 1'b0);
    start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (13) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_hs", {62'd0, out_valid, in_ready}, 64'b01);
    chk("abort_res", {hi, lo}, 64'd0);
    seen = 0;
    repeat (45) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_stale", 64'(seen), 64'd0);
    chk("abort_keep", {hi, lo, 31'd0, div0}, 96'd0);
    run("post_rst", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand width and the width of each result half.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-low reset (rst==0 at a rising edge resets).
REQ-004 Port in_valid, input, 1 bit: an operation request is present.
REQ-005 Port in_ready, output, 1 bit: the block can accept a request.
REQ-006 Port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 Port src_a, input, DATA_WIDTH: the multiplicand or dividend, taken from register-file read port 1.
REQ-008 Port src_b, input, DATA_WIDTH: the multiplier or divisor, taken from register-file read port 2.
REQ-009 Port out_valid, output, 1 bit: the result is present.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 Port hi, output, DATA_WIDTH: the product high half, or the remainder.
REQ-012 Port lo, output, DATA_WIDTH: the product low half, or the quotient.
REQ-013 Port div0, output, 1 bit: the current result came from a divide with src_b==0.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 An edge with in_valid & in_ready SHALL capture op, src_a and src_b, convert signed operands to magnitudes with sign flags, clear the iteration counter, and enter CALC.
REQ-017 CALC SHALL perform exactly DATA_WIDTH iterations, one per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-018 The block SHALL enter DONE on the edge completing iteration DATA_WIDTH-1, so out_valid first rises DATA_WIDTH+1 cycles after the accept edge.
REQ-019 On entry to DONE, sign fix-up SHALL already be applied to hi and lo.
REQ-020 MULT SHALL produce the 2*DATA_WIDTH two's-complement product; MULTU SHALL produce the unsigned product.
REQ-021 DIV SHALL negate the quotient when the operand signs differ, and the remainder sign SHALL follow the dividend.
REQ-022 Signed 0x80000000/0xFFFFFFFF SHALL give lo=0x80000000 and hi=0, wrapping with no flag.
REQ-023 Divide by zero, signed or unsigned, SHALL give lo=all ones, hi=src_a as captured, and div0=1; div0 SHALL be 0 for every other result.
REQ-024 In DONE, hi, lo and div0 SHALL hold stable while out_ready==0.
REQ-025 The edge with out_valid & out_ready SHALL return the block to IDLE.
REQ-026 After that return, hi, lo and div0 SHALL keep the last result until the next DONE entry.
REQ-027 in_valid SHALL be ignored outside IDLE, and changes to src_a, src_b or op after the accept edge SHALL NOT affect the result.
REQ-028 The block SHALL NOT accept a new request in the same cycle as a result handshake; the earliest next accept is one cycle later.

Reset
REQ-029 When rst==0 at an edge, including mid-CALC or in DONE, the state SHALL become IDLE and the counter and internal registers SHALL be cleared.
REQ-030 Reset SHALL set hi=0, lo=0, div0=0 and out_valid=0, with in_ready=1 from the following cycle.
REQ-031 An operation aborted by reset SHALL produce no result.

Structure
REQ-032 The op encodings, the state encodings and DATA_WIDTH SHALL live in the shared codebase header/package used by the other datapath blocks.
REQ-033 The block SHALL be a single module with no sub-module, holding one DATA_WIDTH+1-bit adder/subtractor shared by multiply and divide.
REQ-034 The iteration counter SHALL be clog2(DATA_WIDTH) bits wide.

Verification
REQ-035 MULTU 0xFFFFFFFF*0xFFFFFFFF SHALL give hi=0xFFFFFFFE and lo=0x00000001, with out_valid exactly 33 cycles after accept.
REQ-036 MULT 0xFFFFFFFD*0x00000007 SHALL give hi=0xFFFFFFFF and lo=0xFFFFFFEB.
REQ-037 DIV 0xFFFFFFF9/0x00000002 SHALL give lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-038 DIVU 0x00000064/0 SHALL give lo=0xFFFFFFFF, hi=0x00000064 and div0=1; a following DIVU 100/7 SHALL give lo=14, hi=2 and div0=0.
REQ-039 With out_ready held 0 for 10 cycles in DONE, hi, lo and out_valid SHALL stay stable and in_ready SHALL stay 0.
REQ-040 With out_ready then driven to 1 and in_valid held 1, a new accept SHALL occur exactly one cycle after the handshake.
REQ-041 rst driven to 0 at iteration 12 SHALL give IDLE, out_valid=0 and hi=lo=0 on the next cycle, and no stale result SHALL appear afterwards.
